isw_and_share_driver: RTL and testbench

- Sequencer placed directly upstream of the second-order ISW AND gadget (3 shares, 8-bit lanes, 2-register-stage pipeline). It is also the capture point for the gadget's output.
- Accepts one plaintext operand pair (x, y) through a valid/ready handshake.
- Splits each operand into 3 Boolean shares and generates the 3 refresh randoms from an internal PRNG.
- Holds all gadget inputs stable for the full gadget latency, captures output shares Q0..Q2, and presents them downstream through a valid/ready handshake.

---
 rtl/isw_pkg.sv | 23 ++
 rtl/isw_prng_xorshift64.sv | 28 ++
 rtl/isw_and_share_driver.sv | 183 ++++++++++++++++++
 tb/tb_isw_and_share_driver.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/isw_pkg.sv
// Shared definitions for the ISW AND share driver: default widths/seed, FSM states
// and the xorshift64 step used by the mask generator.
package isw_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam logic [63:0] DEFAULT_SEED = 64'h9E3779B97F4A7C15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        CAPT = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic [63:0] xorshift64_next(input logic [63:0] s);
        logic [63:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

endpackage

// File: rtl/isw_prng_xorshift64.sv
// xorshift64 mask generator: holds its word until strobed; a zero seed would lock the
// generator at zero forever, so it is swapped for the default constant.
module isw_prng_xorshift64
    import isw_pkg::*;
#(
    parameter logic [63:0] SEED = DEFAULT_SEED
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        advance_i,
    output logic [63:0] state_o
);

    localparam logic [63:0] RESET_STATE = (SEED == 64'd0) ? DEFAULT_SEED : SEED;

    logic [63:0] state_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RESET_STATE;
        end else if (advance_i) begin
            state_q <= xorshift64_next(state_q);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/isw_and_share_driver.sv
// Sequencer for the 3-share ISW AND gadget: shares operands, holds gadget inputs for the
// gadget latency, captures Q shares. Build macro ISW_AND_UNMASK_CHECK_EN adds z_o/err_o.
module isw_and_share_driver
    import isw_pkg::*;
#(
    parameter int          WIDTH = DEFAULT_WIDTH,
    parameter int          LAT   = 2,
    parameter logic [63:0] SEED  = DEFAULT_SEED
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] X0_o,
    output logic [WIDTH-1:0] X1_o,
    output logic [WIDTH-1:0] X2_o,
    output logic [WIDTH-1:0] Y0_o,
    output logic [WIDTH-1:0] Y1_o,
    output logic [WIDTH-1:0] Y2_o,
    output logic [WIDTH-1:0] R01_o,
    output logic [WIDTH-1:0] R02_o,
    output logic [WIDTH-1:0] R12_o,
    input  logic [WIDTH-1:0] Q0_i,
    input  logic [WIDTH-1:0] Q1_i,
    input  logic [WIDTH-1:0] Q2_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] Q0_o,
    output logic [WIDTH-1:0] Q1_o,
    output logic [WIDTH-1:0] Q2_o
`ifdef ISW_AND_UNMASK_CHECK_EN
    ,
    output logic [WIDTH-1:0] z_o,
    output logic             err_o
`endif
);

    localparam int CNT_W = $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0][WIDTH-1:0] xSh_q, xSh_d, ySh_q, ySh_d, rnd_q, rnd_d, qSh_q, qSh_d;
    logic advance;
    logic [63:0] prngWord;
    logic [7:0] unusedByte;
    logic [WIDTH-1:0] mx1, mx2, my1, my2;

    isw_prng_xorshift64 #(.SEED(SEED)) uPrng (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .advance_i (advance),
        .state_o   (prngWord)
    );

    // Each mask/random takes the low WIDTH bits of its byte lane; the top byte is spare.
    assign mx1        = prngWord[0  +: WIDTH];
    assign mx2        = prngWord[8  +: WIDTH];
    assign my1        = prngWord[16 +: WIDTH];
    assign my2        = prngWord[24 +: WIDTH];
    assign unusedByte = prngWord[63:56];

`ifdef ISW_AND_UNMASK_CHECK_EN
    logic [WIDTH-1:0] xPt_q, xPt_d, yPt_q, yPt_d, z_q, z_d, unmasked;
    logic err_q, err_d;
    assign unmasked = Q0_i ^ Q1_i ^ Q2_i;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xSh_d   = xSh_q;
        ySh_d   = ySh_q;
        rnd_d   = rnd_q;
        qSh_d   = qSh_q;
        advance = 1'b0;
`ifdef ISW_AND_UNMASK_CHECK_EN
        xPt_d = xPt_q;
        yPt_d = yPt_q;
        z_d   = z_q;
        err_d = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    advance = 1'b1;
                    xSh_d   = {mx2, mx1, x_i ^ mx1 ^ mx2};
                    ySh_d   = {my2, my1, y_i ^ my1 ^ my2};
                    rnd_d   = {prngWord[48 +: WIDTH], prngWord[40 +: WIDTH], prngWord[32 +: WIDTH]};
                    cnt_d   = '0;
                    state_d = HOLD;
`ifdef ISW_AND_UNMASK_CHECK_EN
                    xPt_d = x_i;
                    yPt_d = y_i;
`endif
                end
            end
            HOLD: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                qSh_d   = {Q2_i, Q1_i, Q0_i};
                xSh_d   = '0;
                ySh_d   = '0;
                rnd_d   = '0;
                state_d = DONE;
`ifdef ISW_AND_UNMASK_CHECK_EN
                z_d   = unmasked;
                err_d = (unmasked != (xPt_q & yPt_q));
`endif
            end
            DONE: begin
                if (out_ready_i) begin
                    qSh_d   = '0;
                    state_d = IDLE;
`ifdef ISW_AND_UNMASK_CHECK_EN
                    xPt_d = '0;
                    yPt_d = '0;
                    z_d   = '0;
                    err_d = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            xSh_q   <= '0;
            ySh_q   <= '0;
            rnd_q   <= '0;
            qSh_q   <= '0;
`ifdef ISW_AND_UNMASK_CHECK_EN
            xPt_q <= '0;
            yPt_q <= '0;
            z_q   <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xSh_q   <= xSh_d;
            ySh_q   <= ySh_d;
            rnd_q   <= rnd_d;
            qSh_q   <= qSh_d;
`ifdef ISW_AND_UNMASK_CHECK_EN
            xPt_q <= xPt_d;
            yPt_q <= yPt_d;
            z_q   <= z_d;
            err_q <= err_d;
`endif
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign X0_o  = xSh_q[0];
    assign X1_o  = xSh_q[1];
    assign X2_o  = xSh_q[2];
    assign Y0_o  = ySh_q[0];
    assign Y1_o  = ySh_q[1];
    assign Y2_o  = ySh_q[2];
    assign R01_o = rnd_q[0];
    assign R02_o = rnd_q[1];
    assign R12_o = rnd_q[2];
    assign Q0_o  = qSh_q[0];
    assign Q1_o  = qSh_q[1];
    assign Q2_o  = qSh_q[2];
`ifdef ISW_AND_UNMASK_CHECK_EN
    assign z_o   = z_q;
    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_isw_and_share_driver.sv
// Scoreboard bench for isw_and_share_driver with a behavioural 2-stage ISW gadget;
// define ISW_AND_UNMASK_CHECK_EN to also exercise z_o/err_o.
`timescale 1ns/1ps
module tb_isw_and_share_driver;

    localparam logic [63:0] TB_SEED = 64'h9E3779B97F4A7C15;
    localparam int TB_LAT = 2;

    typedef struct {
        logic [7:0] q0;
        logic [7:0] q1;
        logic [7:0] q2;
        logic [7:0] z;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic inValid, outReady, flipQ1;
    logic [7:0] xIn, yIn;
    logic inReady, outValid, inReady0, outValid0;
    logic [7:0] dX0, dX1, dX2, dY0, dY1, dY2, dR01, dR02, dR12, dQ0o, dQ1o, dQ2o;
    logic [7:0] sX0, sX1, sX2, sY0, sY1, sY2, sR01, sR02, sR12, sQ0o, sQ1o, sQ2o;
    logic [7:0] gQ0, gQ1, gQ2;
    logic [23:0] gStage1, gStage2;
    logic [71:0] dutShares, seed0Shares;
`ifdef ISW_AND_UNMASK_CHECK_EN
    logic [7:0] dZ, sZ;
    logic dErr, sErr;
`endif

    int cmpCount = 0;
    int errCount = 0;
    exp_t sbQ[$];
    exp_t monExp;
    logic [63:0] tbPrng;

    always #5 clk = ~clk;

    isw_and_share_driver #(.WIDTH(8), .LAT(TB_LAT), .SEED(TB_SEED)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(inValid), .in_ready_o(inReady),
        .x_i(xIn), .y_i(yIn),
        .X0_o(dX0), .X1_o(dX1), .X2_o(dX2), .Y0_o(dY0), .Y1_o(dY1), .Y2_o(dY2),
        .R01_o(dR01), .R02_o(dR02), .R12_o(dR12),
        .Q0_i(gQ0), .Q1_i(gQ1), .Q2_i(gQ2),
        .out_valid_o(outValid), .out_ready_i(outReady),
        .Q0_o(dQ0o), .Q1_o(dQ1o), .Q2_o(dQ2o)
`ifdef ISW_AND_UNMASK_CHECK_EN
        , .z_o(dZ), .err_o(dErr)
`endif
    );

    isw_and_share_driver #(.WIDTH(8), .LAT(TB_LAT), .SEED(64'd0)) dutSeed0 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(inValid), .in_ready_o(inReady0),
        .x_i(xIn), .y_i(yIn),
        .X0_o(sX0), .X1_o(sX1), .X2_o(sX2), .Y0_o(sY0), .Y1_o(sY1), .Y2_o(sY2),
        .R01_o(sR01), .R02_o(sR02), .R12_o(sR12),
        .Q0_i(gQ0), .Q1_i(gQ1), .Q2_i(gQ2),
        .out_valid_o(outValid0), .out_ready_i(outReady),
        .Q0_o(sQ0o), .Q1_o(sQ1o), .Q2_o(sQ2o)
`ifdef ISW_AND_UNMASK_CHECK_EN
        , .z_o(sZ), .err_o(sErr)
`endif
    );

    assign dutShares   = {dX0, dX1, dX2, dY0, dY1, dY2, dR01, dR02, dR12};
    assign seed0Shares = {sX0, sX1, sX2, sY0, sY1, sY2, sR01, sR02, sR12};

    function automatic logic [63:0] tbXorshift(input logic [63:0] s);
        logic [63:0] v;
        v = s;
        v = v ^ (v << 13);
        v = v ^ (v >> 7);
        v = v ^ (v << 17);
        return v;
    endfunction

    // Reference ISW AND over shares packed as {x0,x1,x2,y0,y1,y2,r01,r02,r12}.
    function automatic logic [23:0] iswModel(input logic [71:0] sh);
        logic [7:0] x0, x1, x2, y0, y1, y2, r01, r02, r12, c0, c1, c2;
        {x0, x1, x2, y0, y1, y2, r01, r02, r12} = sh;
        c0 = (x0 & y0) ^ r01 ^ r02;
        c1 = (x1 & y1) ^ (r01 ^ (x0 & y1) ^ (x1 & y0)) ^ r12;
        c2 = (x2 & y2) ^ (r02 ^ (x0 & y2) ^ (x2 & y0)) ^ (r12 ^ (x1 & y2) ^ (x2 & y1));
        return {c2, c1, c0};
    endfunction

    always @(posedge clk) begin
        gStage1 <= iswModel(dutShares);
        gStage2 <= gStage1;
    end
    assign gQ0 = gStage2[7:0];
    assign gQ1 = gStage2[15:8] ^ {7'b0, flipQ1};
    assign gQ2 = gStage2[23:16];

    task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] expv);
        cmpCount++;
        if (act !== expv) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every consumed output is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && outValid && outReady) begin
            if (sbQ.size() == 0) begin
                cmpCount++;
                errCount++;
                $display("[TB] FAIL unexpected_out_valid: got 1, expected 0 (t=%0t)", $time);
            end else begin
                monExp = sbQ.pop_front();
                checkOutput("q0", 72'(dQ0o), 72'(monExp.q0));
                checkOutput("q1", 72'(dQ1o), 72'(monExp.q1));
                checkOutput("q2", 72'(dQ2o), 72'(monExp.q2));
                checkOutput("q_unmasked", 72'(dQ0o ^ dQ1o ^ dQ2o), 72'(monExp.z));
`ifdef ISW_AND_UNMASK_CHECK_EN
                checkOutput("z_o", 72'(dZ), 72'(monExp.z));
                checkOutput("err_o", 72'(dErr), 72'(monExp.err));
`endif
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y,
                                 output logic [71:0] expShares, output exp_t e);
        logic [63:0] s;
        logic [23:0] c;
        int n;
        n = 0;
        while (!inReady && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("in_ready_wait", 72'(inReady), 72'd1);
        s = tbPrng;
        expShares = {x ^ s[7:0] ^ s[15:8], s[7:0], s[15:8],
                     y ^ s[23:16] ^ s[31:24], s[23:16], s[31:24],
                     s[39:32], s[47:40], s[55:48]};
        c = iswModel(expShares);
        e.q0  = c[7:0];
        e.q1  = c[15:8] ^ {7'b0, flipQ1};
        e.q2  = c[23:16];
        e.z   = (x & y) ^ {7'b0, flipQ1};
        e.err = flipQ1;
        sbQ.push_back(e);
        tbPrng = tbXorshift(tbPrng);
        xIn = x;
        yIn = y;
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    // Follows one accepted op until out_valid, checking held gadget inputs each cycle.
    task automatic checkFlight(input logic [71:0] expShares);
        int n;
        n = 0;
        checkOutput("in_ready_busy", 72'(inReady), 72'd0);
        while (!outValid && n < 10) begin
            checkOutput("held_shares", dutShares, expShares);
            checkOutput("held_shares_seed0", seed0Shares, expShares);
            @(posedge clk); #1;
            n++;
        end
        checkOutput("latency_edges", 72'(n), 72'(TB_LAT + 1));
        checkOutput("shares_cleared", dutShares, 72'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [71:0] sh;
        exp_t e;
        inValid = 1'b0; outReady = 1'b1; flipQ1 = 1'b0; xIn = '0; yIn = '0;
        tbPrng = TB_SEED;

        #1 rst = 1'b1;
        #1;
        checkOutput("reset_shares", dutShares, 72'd0);
        checkOutput("reset_shares_seed0", seed0Shares, 72'd0);
        checkOutput("reset_q", {48'd0, dQ0o, dQ1o, dQ2o}, 72'd0);
        checkOutput("reset_out_valid", 72'(outValid), 72'd0);
        checkOutput("reset_in_ready", 72'(inReady), 72'd1);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        $display("[TB] op1: x=F0 y=3C");
        applyStimulus(8'hF0, 8'h3C, sh, e);
        checkOutput("op1_seed_masks", dutShares, 72'h99157C_094A7F_B97937);
        checkFlight(sh);
        @(posedge clk); #1;
        checkOutput("op1_idle_after_hs", 72'(inReady), 72'd1);
        checkOutput("op1_q_cleared", {48'd0, dQ0o, dQ1o, dQ2o}, 72'd0);

        $display("[TB] op2: x=FF y=FF with consumer stall");
        outReady = 1'b0;
        applyStimulus(8'hFF, 8'hFF, sh, e);
        checkFlight(sh);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("stall_q_stable", {48'd0, dQ2o, dQ1o, dQ0o}, {48'd0, e.q2, e.q1, e.q0});
            checkOutput("stall_in_ready", 72'(inReady), 72'd0);
            checkOutput("stall_out_valid", 72'(outValid), 72'd1);
        end
        outReady = 1'b1;
        @(posedge clk); #1;
        checkOutput("op2_idle_after_hs", 72'(inReady), 72'd1);
        checkOutput("op2_out_valid_low", 72'(outValid), 72'd0);
        checkOutput("op2_q_cleared", {48'd0, dQ0o, dQ1o, dQ2o}, 72'd0);

        $display("[TB] op3: reset during HOLD");
        applyStimulus(8'hA5, 8'h5A, sh, e);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_shares", dutShares, 72'd0);
        checkOutput("abort_q", {48'd0, dQ0o, dQ1o, dQ2o}, 72'd0);
        checkOutput("abort_out_valid", 72'(outValid), 72'd0);
        checkOutput("abort_in_ready", 72'(inReady), 72'd1);
        sbQ.delete();
        tbPrng = TB_SEED;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("abort_no_valid", 72'(outValid), 72'd0);
        end

        $display("[TB] op4/op5: back-to-back zero operands");
        applyStimulus(8'h00, 8'h00, sh, e);
        checkOutput("post_reset_seed_masks", dutShares, 72'h69157C_354A7F_B97937);
        checkFlight(sh);
        applyStimulus(8'h00, 8'h00, sh, e);
        checkFlight(sh);

`ifdef ISW_AND_UNMASK_CHECK_EN
        $display("[TB] unmask check: 256 random pairs");
        for (int i = 0; i < 256; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), sh, e);
            checkFlight(sh);
        end
        flipQ1 = 1'b1;
        applyStimulus(8'h5C, 8'hE7, sh, e);
        checkFlight(sh);
        @(posedge clk); #1;
        flipQ1 = 1'b0;
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 72'(sbQ.size()), 72'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
